// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC register, IF/ID latch, stall hold, branch redirect and delivery/bubble counters
// Ports: clk, reset (sync, active-high); stall/redirect/redirect_pc control inputs;
// imem_addr -> imem_rdata (1-cycle registered memory); ifid_instr/ifid_pc/ifid_pc4/ifid_valid to ID;
// fetch_count/bubble_count statistics. Define FETCH_PC_WRAP_EN to wrap addresses inside a 128-byte memory.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);
`ifdef FETCH_PC_WRAP_EN
  localparam logic [31:0] ADDR_MASK = 32'h0000_007F;
`else
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d, tgt;
  logic        valid_q, valid_d;
  // The address sent to memory this cycle is exactly what lands in IF/ID on the next edge,
  // so the registered memory output always matches ifid_pc_q.
  always_comb begin
    tgt          = redirect_pc & 32'hFFFF_FFFC & ADDR_MASK;
    ifid_valid   = valid_q & ~redirect;
    imem_addr    = redirect ? tgt : stall ? ifid_pc_q : pc_q;
    ifid_pc_d    = imem_addr;
    pc_d         = (stall & ~redirect) ? pc_q : (imem_addr + 32'd4) & ADDR_MASK;
    valid_d      = (redirect | ~stall) ? 1'b1 : valid_q;
    fetch_cnt_d  = fetch_cnt_q + {31'd0, ifid_valid & ~stall};
    bubble_cnt_d = bubble_cnt_q + {31'd0, stall | ~ifid_valid};
    ifid_instr   = ifid_valid ? imem_rdata : NOP;
    ifid_pc      = ifid_pc_q;
    ifid_pc4     = (ifid_pc_q + 32'd4) & ADDR_MASK;
    fetch_count  = fetch_cnt_q;
    bubble_count = bubble_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      ifid_pc_q    <= '0;
      valid_q      <= 1'b0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      valid_q      <= valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector bench for fetch_stage
module tb_fetch_stage;
`ifdef FETCH_PC_WRAP_EN
  localparam logic [31:0] MASK = 32'h0000_007F;
  localparam logic [31:0] W80 = 32'h0, W84 = 32'h4;
`else
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
  localparam logic [31:0] W80 = 32'h80, W84 = 32'h84;
`endif
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic [31:0] imem_addr, ifid_instr, ifid_pc, ifid_pc4, fetch_count, bubble_count;
  logic ifid_valid;
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] st, rd, rpc, addr, pc, v, f, b;
  } vec_t;
  vec_t tv[18];
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .fetch_count(fetch_count), .bubble_count(bubble_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction
  always @(posedge clk) imem_rdata <= ins(imem_addr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    tv[0]  = '{0, 0, 0,     0,     0,     0, 0, 0};
    tv[1]  = '{0, 0, 0,     4,     0,     1, 0, 1};
    tv[2]  = '{0, 0, 0,     8,     4,     1, 1, 1};
    tv[3]  = '{1, 0, 0,     8,     8,     1, 2, 1};
    tv[4]  = '{1, 0, 0,     8,     8,     1, 2, 2};
    tv[5]  = '{1, 0, 0,     8,     8,     1, 2, 3};
    tv[6]  = '{0, 0, 0,     12,    8,     1, 2, 4};
    tv[7]  = '{0, 0, 0,     16,    12,    1, 3, 4};
    tv[8]  = '{0, 0, 0,     20,    16,    1, 4, 4};
    tv[9]  = '{0, 1, 'h1C,  'h1C,  'h14,  0, 5, 4};
    tv[10] = '{0, 0, 0,     'h20,  'h1C,  1, 5, 5};
    tv[11] = '{1, 1, 'h20,  'h20,  'h20,  0, 6, 5};
    tv[12] = '{0, 0, 0,     'h24,  'h20,  1, 6, 6};
    tv[13] = '{0, 1, 'h23,  'h20,  'h24,  0, 7, 6};
    tv[14] = '{0, 0, 0,     'h24,  'h20,  1, 7, 7};
    tv[15] = '{0, 1, 'h7C,  'h7C,  'h24,  0, 8, 7};
    tv[16] = '{0, 0, 0,     W80,   'h7C,  1, 8, 8};
    tv[17] = '{0, 0, 0,     W84,   W80,   1, 9, 8};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", {31'd0, ifid_valid}, 0);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_instr", ifid_instr, 32'h13);
    chk("rst_fcnt", fetch_count, 0);
    chk("rst_bcnt", bubble_count, 0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      reset = 1'b0;
      stall = tv[i].st[0];
      redirect = tv[i].rd[0];
      redirect_pc = tv[i].rpc;
      #1;
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("v%0d_pc", i), ifid_pc, tv[i].pc);
      chk($sformatf("v%0d_pc4", i), ifid_pc4, (tv[i].pc + 32'd4) & MASK);
      chk($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, tv[i].v);
      chk($sformatf("v%0d_instr", i), ifid_instr, tv[i].v[0] ? ins(tv[i].pc) : 32'h13);
      chk($sformatf("v%0d_fcnt", i), fetch_count, tv[i].f);
      chk($sformatf("v%0d_bcnt", i), bubble_count, tv[i].b);
    end
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    chk("end_fcnt", fetch_count, 10);
    chk("end_bcnt", bubble_count, 8);
    stall = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_stall_valid", {31'd0, ifid_valid}, 0);
    chk("rst_stall_pc", ifid_pc, 0);
    chk("rst_stall_addr", imem_addr, 0);
    chk("rst_stall_instr", ifid_instr, 32'h13);
    chk("rst_stall_fcnt", fetch_count, 0);
    chk("rst_stall_bcnt", bubble_count, 0);
    reset = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    reset = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_redir_pc", ifid_pc, 0);
    chk("rst_redir_valid", {31'd0, ifid_valid}, 0);
    chk("rst_redir_addr", imem_addr, 0);
    chk("rst_redir_fcnt", fetch_count, 0);
    @(negedge clk);
    #1;
    chk("post_rst_pc", ifid_pc, 0);
    chk("post_rst_valid", {31'd0, ifid_valid}, 1);
    chk("post_rst_instr", ifid_instr, ins(0));
    chk("post_rst_addr", imem_addr, 4);
    chk("post_rst_bcnt", bubble_count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
